button_arbiter: RTL and testbench
=================================

BUTTON_ARBITER -- requirements
Module: button_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd50000, consecutive stable cycles required before a debounced level changes; legal range 1..65535.
REQ-002 Parameter HOLDOFF_CYCLES, default 16'd25000, lockout cycles after each grant; legal range 1..65535.
REQ-003 clk  input  1  system clock.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_start, btn_p1, btn_p2  input  1 each  raw, asynchronous, bouncy push-buttons, active-high.
REQ-006 turn  input  2  player allowed to act: 00 none, 01 P1, 10 P2, 11 either.
REQ-007 start_pulse, p1_pulse, p2_pulse  output  1 each  single-cycle accepted-press strobes to the game controller.
REQ-008 lockout  output  1  high while in HOLDOFF.
REQ-009 last_grant  output  2  most recent granted player: 01 P1, 10 P2, 00 none since reset.
REQ-010 reject_cnt  output  8  saturating count of discarded player presses.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each synchronized button SHALL have its own 16-bit debounce counter; the debounced level SHALL take the synchronized value only after that value differs from the debounced level for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle clears the counter.
REQ-013 A press event SHALL be a 0->1 transition of a debounced level; release events SHALL be ignored.
REQ-014 Raw input rising at cycle 0 and stable thereafter SHALL yield its press event in cycle 2+DEBOUNCE_CYCLES and, if granted, its pulse in cycle 3+DEBOUNCE_CYCLES.
REQ-015 Arbiter FSM states: IDLE, GRANT, HOLDOFF.
REQ-016 IDLE: start event SHALL win over any player event in the same cycle; go to GRANT with start_pulse selected.
REQ-017 IDLE: player event SHALL be eligible only if its bit in turn is set; ineligible events SHALL be discarded and increment reject_cnt by one per event.
REQ-018 IDLE: P1 and P2 both eligible in the same cycle (turn=11) SHALL be resolved round-robin: the player not equal to last_grant wins; with last_grant=00 P1 wins; loser SHALL be discarded and counted in reject_cnt.
REQ-019 GRANT: exactly one of the three pulses SHALL be high for exactly one cycle; last_grant SHALL update on player grants only; next state HOLDOFF.
REQ-020 HOLDOFF: lockout=1 for HOLDOFF_CYCLES cycles, then IDLE; every event during HOLDOFF SHALL be dropped (not queued); player events dropped here SHALL increment reject_cnt; start events SHALL not.
REQ-021 Events SHALL never be queued; an event not granted in the cycle it occurs is lost.
REQ-022 reject_cnt SHALL saturate at 8'hFF, no wrap; two simultaneous rejections in one cycle SHALL add 2, saturating.
REQ-023 Pulses SHALL be mutually exclusive in every cycle.
REQ-024 Unused FSM encodings SHALL return to IDLE on the next clock.

Reset
REQ-025 reset_n low SHALL immediately force: FSM IDLE, all pulses 0, lockout 0, last_grant 00, reject_cnt 0, synchronizers 0, debounced levels 0, all counters 0.
REQ-026 Reset mid-HOLDOFF or mid-debounce SHALL abandon the operation; a button held through reset release SHALL produce one press event after the full REQ-014 latency.

Structure
REQ-027 Shared package game_pkg SHALL hold the turn/player encodings (NONE=00, P1=01, P2=10, ANY=11) and the arbiter state encoding.
REQ-028 One sub-module, button_debouncer (synchronizer + counter + rising-edge detect), SHALL be instantiated three times.

Verification (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8)
REQ-029 btn_p1 held high from cycle 0, turn=01 -> p1_pulse high in cycle 7 only, lockout high cycles 8-15, last_grant=01.
REQ-030 btn_p1 toggling every 2 cycles for 20 cycles then stable high, turn=01 -> exactly one p1_pulse, 7 cycles after stabilization.
REQ-031 btn_p2 press with turn=01 -> no pulse, reject_cnt 0->1.
REQ-032 btn_start and btn_p1 edges in same cycle, turn=01 -> start_pulse only, reject_cnt +1 (P1 dropped).
REQ-033 turn=11, P1 and P2 simultaneous twice (separated by >HOLDOFF) -> first p1_pulse, second p2_pulse, reject_cnt +2.
REQ-034 300 rejected presses -> reject_cnt holds 8'hFF; reset_n pulsed low mid-HOLDOFF -> lockout, reject_cnt, last_grant 0 immediately.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the game button front end.
// Player/turn codes, arbiter states and a saturating adder.
package game_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        P1   = 2'b01,
        P2   = 2'b10,
        ANY  = 2'b11
    } player_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        HOLDOFF = 2'b10
    } arb_state_e;

    function automatic logic [7:0] sat_add8(
        input logic [7:0] a,
        input logic [1:0] b
    );
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizer, debounce counter and press detector for one button.
// press_o is a registered one-cycle strobe on a debounced 0->1 edge.
module button_debouncer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic press_o
);

    logic        sync1_q;
    logic        sync2_q;
    logic        deb_q;
    logic        deb_d;
    logic        deb_prev_q;
    logic        press_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Two-flop synchronizer for the raw asynchronous input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive mismatch cycles; flip level on the last one.
    always_comb begin
        cnt_d = 16'd0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Debounced level, its delayed copy and the registered press strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= 16'd0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/button_arbiter.sv
// Debounces start/P1/P2 and arbitrates presses into one-cycle strobes.
// After every grant the arbiter locks out all presses for a holdoff.
module button_arbiter
    import game_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] HOLDOFF_CYCLES  = 16'd25000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_p1,
    input  logic       btn_p2,
    input  logic [1:0] turn,
    output logic       start_pulse,
    output logic       p1_pulse,
    output logic       p2_pulse,
    output logic       lockout,
    output logic [1:0] last_grant,
    output logic [7:0] reject_cnt
);

    logic start_ev;
    logic p1_ev;
    logic p2_ev;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_start),
        .press_o (start_ev)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1 (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_p1),
        .press_o (p1_ev)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2 (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_p2),
        .press_o (p2_ev)
    );

    arb_state_e  state_q;
    logic [15:0] hold_cnt_q;
    logic        start_pulse_q;
    logic        p1_pulse_q;
    logic        p2_pulse_q;
    logic        lockout_q;
    player_e     last_grant_q;
    logic [7:0]  reject_cnt_q;

    logic       p1_ok;
    logic       p2_ok;
    logic       both_ok;
    logic       rr_p2;
    logic       g_start;
    logic       g_p1;
    logic       g_p2;
    logic       granted;
    logic [1:0] ev_cnt;
    logic [1:0] idle_rej;

    // Pick the winner among this cycle's events if the arbiter is idle.
    always_comb begin
        p1_ok    = p1_ev & turn[0];
        p2_ok    = p2_ev & turn[1];
        both_ok  = p1_ok & p2_ok;
        rr_p2    = (last_grant_q == P1);
        g_start  = 1'b0;
        g_p1     = 1'b0;
        g_p2     = 1'b0;
        unique case (1'b1)
            start_ev:                              g_start = 1'b1;
            !start_ev && both_ok && rr_p2:         g_p2    = 1'b1;
            !start_ev && both_ok && !rr_p2:        g_p1    = 1'b1;
            !start_ev && p1_ok && !p2_ok:          g_p1    = 1'b1;
            !start_ev && p2_ok && !p1_ok:          g_p2    = 1'b1;
            default: ;
        endcase
        granted  = g_start | g_p1 | g_p2;
        ev_cnt   = {1'b0, p1_ev} + {1'b0, p2_ev};
        idle_rej = ev_cnt - {1'b0, g_p1 | g_p2};
    end

    // Arbiter FSM with registered strobes, lockout and reject counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            hold_cnt_q    <= 16'd0;
            start_pulse_q <= 1'b0;
            p1_pulse_q    <= 1'b0;
            p2_pulse_q    <= 1'b0;
            lockout_q     <= 1'b0;
            last_grant_q  <= NONE;
            reject_cnt_q  <= 8'd0;
        end else begin
            start_pulse_q <= 1'b0;
            p1_pulse_q    <= 1'b0;
            p2_pulse_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    lockout_q    <= 1'b0;
                    reject_cnt_q <= sat_add8(reject_cnt_q, idle_rej);
                    if (granted) begin
                        state_q       <= GRANT;
                        start_pulse_q <= g_start;
                        p1_pulse_q    <= g_p1;
                        p2_pulse_q    <= g_p2;
                        if (g_p1) last_grant_q <= P1;
                        if (g_p2) last_grant_q <= P2;
                    end
                end
                GRANT: begin
                    reject_cnt_q <= sat_add8(reject_cnt_q, ev_cnt);
                    state_q      <= HOLDOFF;
                    lockout_q    <= 1'b1;
                    hold_cnt_q   <= 16'd0;
                end
                HOLDOFF: begin
                    reject_cnt_q <= sat_add8(reject_cnt_q, ev_cnt);
                    if (hold_cnt_q == HOLDOFF_CYCLES - 16'd1) begin
                        state_q    <= IDLE;
                        lockout_q  <= 1'b0;
                        hold_cnt_q <= 16'd0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    lockout_q  <= 1'b0;
                    hold_cnt_q <= 16'd0;
                end
            endcase
        end
    end

    assign start_pulse = start_pulse_q;
    assign p1_pulse    = p1_pulse_q;
    assign p2_pulse    = p2_pulse_q;
    assign lockout     = lockout_q;
    assign last_grant  = last_grant_q;
    assign reject_cnt  = reject_cnt_q;

endmodule

// File: tb/tb_button_arbiter.sv
// Randomized and directed bench for button_arbiter.
// A cycle-indexed reference model predicts every output each cycle.
module tb_button_arbiter;

    localparam int D = 4;
    localparam int H = 8;

    logic       clk;
    logic       reset_n;
    logic       btn_start;
    logic       btn_p1;
    logic       btn_p2;
    logic [1:0] turn;
    logic       start_pulse;
    logic       p1_pulse;
    logic       p2_pulse;
    logic       lockout;
    logic [1:0] last_grant;
    logic [7:0] reject_cnt;

    button_arbiter #(
        .DEBOUNCE_CYCLES(16'(D)),
        .HOLDOFF_CYCLES (16'(H))
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_start   (btn_start),
        .btn_p1      (btn_p1),
        .btn_p2      (btn_p2),
        .turn        (turn),
        .start_pulse (start_pulse),
        .p1_pulse    (p1_pulse),
        .p2_pulse    (p2_pulse),
        .lockout     (lockout),
        .last_grant  (last_grant),
        .reject_cnt  (reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: sync delay line, window of the last D
    // synchronized samples, and grant bookkeeping by cycle number.
    int       m_cyc;
    int       m_g;
    int       m_which;
    int       m_rej;
    bit [1:0] m_last;
    bit       m_s1   [3];
    bit       m_s2   [3];
    bit       m_deb  [3];
    bit       m_dprev[3];
    bit       m_ev   [3];
    bit       m_win  [3][D];

    task automatic model_reset();
        m_cyc = 0; m_g = -1000; m_which = 0; m_rej = 0; m_last = 2'b00;
        for (int b = 0; b < 3; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0;
            m_dprev[b] = 0; m_ev[b] = 0;
            for (int j = 0; j < D; j++) m_win[b][j] = 0;
        end
    endtask

    task automatic model_edge(input bit r0, input bit r1, input bit r2,
                              input logic [1:0] t);
        int  n;
        int  win;
        bit  ok1;
        bit  ok2;
        bit  alld;
        bit  r[3];
        n = m_cyc + 1;
        r[0] = r0; r[1] = r1; r[2] = r2;
        if (n - 1 > m_g + H) begin
            ok1 = m_ev[1] & t[0];
            ok2 = m_ev[2] & t[1];
            win = 0;
            if (m_ev[0]) win = 1;
            else if (ok1 && ok2) win = (m_last == 2'b01) ? 3 : 2;
            else if (ok1) win = 2;
            else if (ok2) win = 3;
            m_rej += int'(m_ev[1]) + int'(m_ev[2]) - ((win >= 2) ? 1 : 0);
            if (win != 0) begin
                m_g = n;
                m_which = win;
                if (win == 2) m_last = 2'b01;
                if (win == 3) m_last = 2'b10;
            end
        end else begin
            m_rej += int'(m_ev[1]) + int'(m_ev[2]);
        end
        if (m_rej > 255) m_rej = 255;
        for (int b = 0; b < 3; b++) begin
            m_ev[b] = m_deb[b] & ~m_dprev[b];
            m_dprev[b] = m_deb[b];
            for (int j = 0; j < D - 1; j++) m_win[b][j] = m_win[b][j+1];
            m_win[b][D-1] = m_s2[b];
            alld = 1;
            for (int j = 0; j < D; j++)
                if (m_win[b][j] == m_deb[b]) alld = 0;
            if (alld) m_deb[b] = ~m_deb[b];
            m_s2[b] = m_s1[b];
            m_s1[b] = r[b];
        end
        m_cyc = n;
    endtask

    function automatic logic [2:0] exp_pulses();
        if (m_g != m_cyc) return 3'b000;
        case (m_which)
            1: return 3'b100;
            2: return 3'b010;
            3: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic tick(input bit r0, input bit r1, input bit r2,
                        input logic [1:0] t);
        btn_start = r0; btn_p1 = r1; btn_p2 = r2; turn = t;
        model_edge(r0, r1, r2, t);
        @(posedge clk);
        @(negedge clk);
        check("pulses", {start_pulse, p1_pulse, p2_pulse}, exp_pulses());
        check("lockout", lockout,
              (m_cyc > m_g && m_cyc <= m_g + H) ? 1 : 0);
        check("last_grant", last_grant, m_last);
        check("reject_cnt", reject_cnt, m_rej);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_pulses", {start_pulse, p1_pulse, p2_pulse}, 3'b000);
        check("rst_lockout", lockout, 1'b0);
        check("rst_last", last_grant, 2'b00);
        check("rst_reject", reject_cnt, 8'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_s, c_1, c_2, k7;
        int hold[3];
        bit lvl[3];
        logic [1:0] t;

        reset_n = 1'b0; btn_start = 0; btn_p1 = 0; btn_p2 = 0; turn = 2'b00;
        @(negedge clk);

        // Held P1 press, turn P1.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            tick(0, 1, 0, 2'b01);
            check("p1_cycle7", p1_pulse, (k == 7) ? 1 : 0);
            check("lock_8_15", lockout, (k >= 8 && k <= 15) ? 1 : 0);
        end
        check("last_p1", last_grant, 2'b01);

        // Bouncing P1, then stable high from k=20.
        tick(0, 0, 0, 2'b01);
        do_reset();
        c_1 = 0; k7 = -1;
        for (int k = 0; k < 40; k++) begin
            tick(0, (k >= 20) ? 1'b1 : ((k / 2) % 2 == 0), 0, 2'b01);
            if (p1_pulse) begin c_1++; k7 = k; end
        end
        check("bounce_cnt", c_1, 1);
        check("bounce_at", k7, 27);

        // P2 press while only P1 may act.
        do_reset();
        c_2 = 0;
        for (int k = 0; k < 14; k++) begin
            tick(0, 0, 1, 2'b01);
            c_2 += int'(p2_pulse);
        end
        check("p2_none", c_2, 0);
        check("p2_reject", reject_cnt, 8'd1);

        // Start and P1 together: start wins, P1 counted.
        do_reset();
        c_s = 0; c_1 = 0;
        for (int k = 0; k < 14; k++) begin
            tick(1, 1, 0, 2'b01);
            c_s += int'(start_pulse); c_1 += int'(p1_pulse);
        end
        check("sp_start", c_s, 1);
        check("sp_p1", c_1, 0);
        check("sp_reject", reject_cnt, 8'd1);

        // Round-robin on simultaneous P1/P2, turn any.
        do_reset();
        c_1 = 0; c_2 = 0;
        for (int k = 0; k < 60; k++) begin
            tick(0, (k < 10) || (k >= 30 && k < 40),
                    (k < 10) || (k >= 30 && k < 40), 2'b11);
            c_1 += int'(p1_pulse); c_2 += int'(p2_pulse);
        end
        check("rr_p1", c_1, 1);
        check("rr_p2", c_2, 1);
        check("rr_reject", reject_cnt, 8'd2);
        check("rr_last", last_grant, 2'b10);

        // 300 rejected presses saturate, then reset mid-holdoff.
        do_reset();
        for (int p = 0; p < 300; p++)
            for (int k = 0; k < 12; k++) tick(0, k < 6, 0, 2'b00);
        check("sat_ff", reject_cnt, 8'hFF);
        for (int k = 0; k < 11; k++) tick(0, 1, 0, 2'b01);
        check("pre_rst_lock", lockout, 1'b1);
        check("pre_rst_last", last_grant, 2'b01);
        btn_p1 = 0;
        do_reset();

        // Random presses, turns and occasional resets.
        for (int b = 0; b < 3; b++) begin hold[b] = 0; lvl[b] = 0; end
        t = 2'b11;
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    lvl[b] = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 10);
                end
                hold[b]--;
            end
            if ($urandom_range(0, 39) == 0) t = 2'($urandom_range(0, 3));
            tick(lvl[0], lvl[1], lvl[2], t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
